// File: rtl/mmio_data_memory.sv
// mmio_data_memory: data-side RAM plus MMIO window (LED, cycle counter, serial TX with FIFO)
// Optional cycle counter at 0x8000_0004 is built only when MMIO_CYCLE_COUNTER_EN is defined.
module mmio_data_memory #(
    parameter int RAM_WORDS    = 64,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] adr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [7:0]  leds,
    output logic        tx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    leds_q, leds_d;
    state_t        state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic [31:0]   cycle_val;
    logic [31:0]   txstat;
    logic          reg_hit, led_sel, txd_sel, full, empty, pop, push, tick_end;
    logic          unused_adr;

    assign unused_adr = ^adr[1:0];
    assign reg_hit    = adr[31] && (adr[30:4] == 27'd0);
    assign led_sel    = reg_hit && (adr[3:2] == 2'd0);
    assign txd_sel    = reg_hit && (adr[3:2] == 2'd2);
    assign full       = count_q == CW'(FIFO_DEPTH);
    assign empty      = count_q == '0;
    assign tick_end   = tick_q == TICK_LAST;
    assign pop        = !empty && (state_q == IDLE || (state_q == STOP && tick_end));
    assign push       = write_enable && txd_sel && (!full || pop);
    assign txstat     = {24'd0, 4'(count_q), 1'b0, state_q != IDLE, empty, full};
    assign leds       = leds_q;
    assign tx         = tx_q;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;
    // free-running counter, wraps naturally at 2^32
    always_comb cycle_d = cycle_q + 32'd1;
    // counter register
    always_ff @(posedge clk) cycle_q <= reset ? 32'd0 : cycle_d;
    assign cycle_val = cycle_q;
`else
    assign cycle_val = 32'd0;
`endif

    // load mux: RAM below 0x8000_0000, register window above, zero elsewhere
    always_comb begin
        dout = !adr[31] ? ram[adr[AW+1:2]] :
               !reg_hit ? 32'd0 :
               adr[3:2] == 2'd0 ? {24'd0, leds_q} :
               adr[3:2] == 2'd1 ? cycle_val :
               adr[3:2] == 2'd3 ? txstat : 32'd0;
    end

    // next-state for LED register and FIFO bookkeeping
    always_comb begin
        leds_d   = (write_enable && led_sel) ? din[7:0] : leds_q;
        wr_ptr_d = wr_ptr_q + FW'(push);
        rd_ptr_d = rd_ptr_q + FW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // storage arrays: RAM and FIFO slots are never cleared by reset
    always_ff @(posedge clk) begin
        if (write_enable && !adr[31]) ram[adr[AW+1:2]] <= din;
        if (push) fifo_q[wr_ptr_q] <= din[7:0];
    end

    // LED and FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            leds_q   <= leds_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // serial transmitter: start bit, 8 data bits LSB first, stop bit; back-to-back when queued
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            tick_q <= (state_q == IDLE || tick_end) ? '0 : tick_q + TW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    shift_q <= fifo_q[rd_ptr_q];
                    tx_q    <= 1'b0;
                end
                START: if (tick_end) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                end
                DATA: if (tick_end) begin
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end
                default: if (tick_end) begin
                    state_q <= pop ? START : IDLE;
                    tx_q    <= !pop;
                    if (pop) shift_q <= fifo_q[rd_ptr_q];
                end
            endcase
        end
    end
endmodule
